// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for register-register ALU instructions.
// Optional CU_STOP_EN adds a Stop input that halts after the current instruction.
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             Clock,
  input  logic             Clear,
`ifdef CU_STOP_EN
  input  logic             Stop,
`endif
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             Zlowout,
  output logic             ZHighout,
  output logic             MDRout,
  output logic             HIout,
  output logic             LOout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [OPW-1:0]   ALUop,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic [2:0]       Tstate,
  output logic             Illegal
);

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_SHR = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ROR = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_ROL = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_AND = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_OR  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_MUL = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NEG = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NOT = OPW'(5'b10010);

  state_t state, state_nxt;

  logic [OPW-1:0] opcode;
  logic [3:0]     ra, rb, rc;
  logic           legal, muldiv, unary;
  logic           stop_hit;
  logic           final_cyc;

  assign opcode = IR[31 -: OPW];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  // Out-of-range register fields select nothing.
  function automatic logic [NREGS-1:0] sel(input logic [3:0] f);
    sel = (32'(f) < NREGS) ? (NREGS'(1) << f) : '0;
  endfunction

  always_comb begin
    legal  = 1'b1;
    muldiv = 1'b0;
    unary  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: ;
      OP_MUL, OP_DIV: muldiv = 1'b1;
      OP_NEG, OP_NOT: unary  = 1'b1;
      default:        legal  = 1'b0;
    endcase
  end

  assign final_cyc = (state == T6) ||
                     (state == T5 && !muldiv);

`ifdef CU_STOP_EN
  // Stop seen anywhere in an instruction is held until its last cycle.
  logic stop_pend;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)
      stop_pend <= 1'b0;
    else if (final_cyc || state == HALT)
      stop_pend <= 1'b0;
    else
      stop_pend <= stop_pend | Stop;
  end

  assign stop_hit = Stop | stop_pend;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state   <= T0;
      Illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == T3 && !legal)
        Illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      T0:   state_nxt = T1;
      T1:   state_nxt = T2;
      T2:   state_nxt = T3;
      T3:   state_nxt = legal ? T4 : HALT;
      T4:   state_nxt = T5;
      T5:   state_nxt = muldiv ? T6 :
                        (stop_hit ? HALT : T0);
      T6:   state_nxt = stop_hit ? HALT : T0;
      HALT: state_nxt = HALT;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ALUop    = '0;
    Rout     = '0;
    Rin      = '0;
    unique case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (legal && !unary) begin
          Rout = sel(rb);
          Yin  = 1'b1;
        end
      end
      T4: begin
        Rout  = unary ? sel(rb) : sel(rc);
        ALUop = opcode;
        Zin   = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
        if (muldiv)
          LOin = 1'b1;
        else
          Rin = sel(ra);
      end
      T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
      end
      HALT: ;
    endcase
  end

  assign Tstate = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes expected control words,
// a negedge monitor pops and compares. Define CU_STOP_EN to exercise Stop.
module tb_control_sequencer;

  localparam int NREGS = 16;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR    = '0;
`ifdef CU_STOP_EN
  logic        Stop  = 1'b0;
`endif
  logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout;
  logic MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic IncPC, Read, Illegal;
  logic [4:0]       ALUop;
  logic [NREGS-1:0] Rout, Rin;
  logic [2:0]       Tstate;

  control_sequencer #(.NREGS(NREGS), .OPW(5)) dut (
    .Clock(Clock), .Clear(Clear),
`ifdef CU_STOP_EN
    .Stop(Stop),
`endif
    .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .ALUop(ALUop),
    .Rout(Rout), .Rin(Rin), .Tstate(Tstate), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] t;
    logic ill;
    logic pcout, zlo, zhi, mdrout, hiout, loout;
    logic marin, pcin, mdrin, irin, yin, zin, hiin, loin;
    logic incpc, read;
    logic [4:0] aluop;
    logic [NREGS-1:0] rout, rin;
  } ctl_t;

  ctl_t exp_q[$];
  ctl_t seq[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   running    = 0;
  bit   seq_halts;

  logic [4:0] ops2 [8] = '{5'd3, 5'd4, 5'd5, 5'd6,
                           5'd7, 5'd8, 5'd9, 5'd10};
  logic [4:0] opsmd[2] = '{5'd15, 5'd16};
  logic [4:0] opsun[2] = '{5'd17, 5'd18};

  function automatic ctl_t blank(input int t);
    ctl_t w;
    w   = '0;
    w.t = 3'(t);
    return w;
  endfunction

  function automatic ctl_t t0_w();
    ctl_t w;
    w = blank(0);
    w.pcout = 1; w.marin = 1; w.incpc = 1; w.zin = 1;
    return w;
  endfunction

  function automatic logic [NREGS-1:0] onehot(input int f);
    return (f < NREGS) ? (NREGS'(1) << f) : '0;
  endfunction

  function automatic bit in_list2(input logic [4:0] op);
    foreach (ops2[i]) if (ops2[i] == op) return 1;
    return 0;
  endfunction

  // Expected per-cycle control words of one instruction, from the strobe table.
  task automatic build(input logic [31:0] ir);
    logic [4:0] op;
    int ra, rb, rc;
    bit md, un, ok;
    ctl_t w;
    op = ir[31:27];
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    md = (op == opsmd[0]) || (op == opsmd[1]);
    un = (op == opsun[0]) || (op == opsun[1]);
    ok = md || un || in_list2(op);
    seq.delete();
    seq.push_back(t0_w());
    w = blank(1);
    w.zlo = 1; w.pcin = 1; w.read = 1; w.mdrin = 1;
    seq.push_back(w);
    w = blank(2);
    w.mdrout = 1; w.irin = 1;
    seq.push_back(w);
    w = blank(3);
    if (ok && !un) begin
      w.rout = onehot(rb); w.yin = 1;
    end
    seq.push_back(w);
    seq_halts = !ok;
    if (!ok) return;
    w = blank(4);
    w.rout  = un ? onehot(rb) : onehot(rc);
    w.aluop = op; w.zin = 1;
    seq.push_back(w);
    w = blank(5);
    w.zlo = 1;
    if (md) w.loin = 1;
    else    w.rin  = onehot(ra);
    seq.push_back(w);
    if (md) begin
      w = blank(6);
      w.zhi = 1; w.hiin = 1;
      seq.push_back(w);
    end
  endtask

  task automatic step(input ctl_t e);
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step(t0_w());
    Clear = 1'b0;
  endtask

  // pulse: index at which Clear is pulsed mid-cycle (-1 none);
  // stop3: raise Stop during T3 only.
  task automatic run_instr(input logic [31:0] ir, input int pulse,
                           input bit stop3);
    int   i;
    ctl_t hw;
    bit   halts;
    build(ir);
    halts = seq_halts;
    IR = ir;
    i = 0;
    while (i < seq.size()) begin
      if (i == pulse) begin
        exp_q.push_back(t0_w());
        #1 Clear = 1'b1;
        #2 Clear = 1'b0;
        @(posedge Clock);
        #1;
        pulse = -1;
        i = 1;
        continue;
      end
`ifdef CU_STOP_EN
      Stop = stop3 && (i == 3);
`endif
      step(seq[i]);
      i++;
    end
`ifdef CU_STOP_EN
    Stop = 1'b0;
`endif
    if (halts || stop3) begin
      hw = blank(7);
      hw.ill = halts;
      repeat (3) step(hw);
      do_clear();
    end
  endtask

  initial begin
    ctl_t got, e;
    forever begin
      @(negedge Clock);
      if (running) begin
        got = '{t: Tstate, ill: Illegal,
                pcout: PCout, zlo: Zlowout, zhi: ZHighout,
                mdrout: MDRout, hiout: HIout, loout: LOout,
                marin: MARin, pcin: PCin, mdrin: MDRin,
                irin: IRin, yin: Yin, zin: Zin, hiin: HIin,
                loin: LOin, incpc: IncPC, read: Read,
                aluop: ALUop, rout: Rout, rin: Rin};
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL underflow t=%0t got=%h required=none",
                   $time, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            mismatched++;
            $display("FAIL ctrl_word t=%0t got=%h required=%h",
                     $time, got, e);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ir;
    int pulse;
    @(posedge Clock);
    #1;
    running = 1;
    step(t0_w());
    step(t0_w());
    Clear = 1'b0;
    run_instr(32'h4A920000, -1, 0);
    run_instr(32'h7A920000, -1, 0);
    run_instr(32'h4A920000, 4, 0);
    run_instr(32'hF8000000, -1, 0);
    run_instr(32'h8A920000, -1, 0);
`ifdef CU_STOP_EN
    run_instr(32'h4A920000, -1, 1);
    run_instr(32'h7A920000, -1, 1);
`endif
    for (int n = 0; n < 60; n++) begin
      ir = $urandom;
      case ($urandom_range(0, 9))
        0, 1: ;
        2:    ir[31:27] = opsmd[$urandom_range(0, 1)];
        3:    ir[31:27] = opsun[$urandom_range(0, 1)];
        default: ir[31:27] = ops2[$urandom_range(0, 7)];
      endcase
      pulse = ($urandom_range(0, 7) == 0) ?
              int'($urandom_range(1, 4)) : -1;
      run_instr(ir, pulse, 0);
    end
    running = 0;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
